// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - run monitor: snoops register writes and retires, counts a run, and reports its verdict
module run_monitor #(
    parameter int XLEN       = 64,
    parameter int NUM_WATCH  = 3,
    parameter int WATCH_BASE = 27,
    parameter int DONE_REG   = 26,
    parameter int PASS_REG   = 27,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [4:0]                wr_addr,
    input  logic [XLEN-1:0]           wr_data,
    input  logic                      retire,
    input  logic [CNT_W-1:0]          max_cycles,
    output logic [1:0]                state,
    output logic                      pass,
    output logic                      fail,
    output logic [CNT_W-1:0]          cycles,
    output logic [CNT_W-1:0]          instret,
    output logic [NUM_WATCH*XLEN-1:0] watch_val,
    output logic [NUM_WATCH*8-1:0]    watch_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cycles_inc;
    logic             wr_ok;
    logic             done_hit;
    logic             timeout_hit;
    logic             pass_shadow;
    logic             run_active;
    logic             set_verdict;

    assign state       = state_q;
    assign wr_ok       = wr_en && (wr_addr != 5'd0);
    assign done_hit    = wr_ok && (wr_addr == 5'(DONE_REG)) && (wr_data != '0);
    assign cycles_inc  = cycles + CNT_W'(1);
    assign timeout_hit = (max_cycles != '0) && (cycles_inc == max_cycles);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A DONE write outranks a timeout landing on the same edge.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_RUN;
                S_RUN: begin
                    if (done_hit) begin
                        state_d = S_DONE;
                    end else if (timeout_hit) begin
                        state_d = S_TIMEOUT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        run_active  = (state_q == S_RUN) && !clear;
        set_verdict = run_active && done_hit;
    end

    // The verdict samples the shadow before this cycle's write, so DONE_REG==PASS_REG sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass        <= 1'b0;
            fail        <= 1'b0;
            pass_shadow <= 1'b0;
            cycles      <= '0;
            instret     <= '0;
            watch_val   <= '0;
            watch_cnt   <= '0;
        end else if (clear) begin
            pass        <= 1'b0;
            fail        <= 1'b0;
            pass_shadow <= 1'b0;
            cycles      <= '0;
            instret     <= '0;
            watch_val   <= '0;
            watch_cnt   <= '0;
        end else if (run_active) begin
            cycles <= cycles_inc;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
            if (wr_ok && (wr_addr == 5'(PASS_REG))) begin
                pass_shadow <= (wr_data == XLEN'(1));
            end
            if (set_verdict) begin
                pass <= pass_shadow;
                fail <= !pass_shadow;
            end
            for (int i = 0; i < NUM_WATCH; i++) begin
                if (wr_ok && (int'(wr_addr) == WATCH_BASE + i)) begin
                    watch_val[i*XLEN +: XLEN] <= wr_data;
                    if (watch_cnt[i*8 +: 8] != 8'hff) begin
                        watch_cnt[i*8 +: 8] <= watch_cnt[i*8 +: 8] + 8'd1;
                    end
                end
            end
        end
    end

endmodule
